// File: rtl/rr_grant_scheduler_pkg.sv
// Shared definitions for the round-robin grant scheduler: FSM state codes,
// default sizing constants and the index-width helper.
package rr_grant_scheduler_pkg;

  localparam int RR_DEFAULT_WIDTH   = 4;
  localparam int RR_DEFAULT_TIMEOUT = 16;

  // FSM state codes (kept as plain constants for compatibility with older blocks)
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_GRANT = 2'd1;
  localparam state_t ST_HOLD  = 2'd2;

  // Bits needed to index n items; never below 1 so vectors stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_grant_scheduler_pick.sv
// Combinational rotating-priority picker: returns the first requester found
// when scanning from ptr upwards with wrap-around, plus a found flag.
module rr_grant_scheduler_pick
  import rr_grant_scheduler_pkg::*;
#(
  parameter int WIDTH = RR_DEFAULT_WIDTH,
  parameter int IW    = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    winner,
  output logic             found
);

  logic [IW:0]    idx_sum [WIDTH];
  logic [IW-1:0]  idx     [WIDTH];
  logic [WIDTH-1:0] hit;

  // Slot gi of the scan looks at requester (ptr + gi) mod WIDTH; ptr is
  // always below WIDTH, so a single conditional subtract is enough.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slot
    assign idx_sum[gi] = {1'b0, ptr} + (IW+1)'(gi);
    assign idx[gi]     = (idx_sum[gi] >= (IW+1)'(WIDTH))
                         ? IW'(idx_sum[gi] - (IW+1)'(WIDTH))
                         : IW'(idx_sum[gi]);
    assign hit[gi]     = req[idx[gi]];
  end

  // Lowest scan slot with a request wins (walk downwards so it lands last).
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (hit[i]) begin
        winner = idx[i];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler for a shared load path. Grants one requester at a
// time, strobes load until ack, then holds the grant until the winner drops
// its request. Optional grant watchdog enabled by defining RR_SCHED_TIMEOUT_EN.
module rr_grant_scheduler
  import rr_grant_scheduler_pkg::*;
#(
  parameter int WIDTH   = RR_DEFAULT_WIDTH,
  parameter int TIMEOUT = RR_DEFAULT_TIMEOUT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           req,
  input  logic                       ack,
  output logic [WIDTH-1:0]           grant,
  output logic [idx_width(WIDTH)-1:0] grant_id,
  output logic                       load,
  output logic                       busy,
  output logic                       timeout
);

  localparam int IW = idx_width(WIDTH);

  state_t           state_reg,    state_next;
  logic [IW-1:0]    ptr_reg,      ptr_next;
  logic [WIDTH-1:0] grant_reg,    grant_next;
  logic [IW-1:0]    grant_id_reg, grant_id_next;
  logic             load_reg,     load_next;
  logic             timeout_next;

  logic [IW-1:0]    winner;
  logic             found;
  logic [IW-1:0]    ptr_after;

  rr_grant_scheduler_pick #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .winner (winner),
    .found  (found)
  );

  // Pointer value that puts the current holder last in the next scan.
  assign ptr_after = (grant_id_reg == IW'(WIDTH - 1)) ? '0 : grant_id_reg + 1'b1;

`ifdef RR_SCHED_TIMEOUT_EN
  localparam int CW = idx_width(TIMEOUT) + 1;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          expired;
  logic          timeout_reg;

  // Watchdog fires on the last permitted cycle of GRANT or HOLD.
  assign expired = (state_reg != ST_IDLE) && (cnt_reg == CW'(TIMEOUT - 1));

  // Cycle counter restarts on every new grant and runs while a grant is live.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg == ST_IDLE) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Counter and timeout pulse registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign timeout = timeout_reg;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT > 0);
  assign timeout = 1'b0;
`endif

  // Next-state logic: new grant from IDLE, ack/withdraw in GRANT, release in HOLD.
  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    grant_next    = grant_reg;
    grant_id_next = grant_id_reg;
    load_next     = load_reg;
    timeout_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (found) begin
          grant_next         = '0;
          grant_next[winner] = 1'b1;
          grant_id_next      = winner;
          load_next          = 1'b1;
          state_next         = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // ack beats a same-cycle withdraw; the release is seen in HOLD.
        if (ack) begin
          load_next  = 1'b0;
          ptr_next   = ptr_after;
          state_next = ST_HOLD;
        end else if (!req[grant_id_reg]) begin
          grant_next = '0;
          load_next  = 1'b0;
          state_next = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!req[grant_id_reg]) begin
          grant_next = '0;
          state_next = ST_IDLE;
        end
      end
      default: begin
        grant_next = '0;
        load_next  = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
`ifdef RR_SCHED_TIMEOUT_EN
    // Revocation overrides ack and release decided above.
    if (expired) begin
      grant_next   = '0;
      load_next    = 1'b0;
      ptr_next     = ptr_after;
      timeout_next = 1'b1;
      state_next   = ST_IDLE;
    end
`endif
  end

  // Main state and output registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= '0;
      grant_reg    <= '0;
      grant_id_reg <= '0;
      load_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      grant_reg    <= grant_next;
      grant_id_reg <= grant_id_next;
      load_reg     <= load_next;
    end
  end

  assign grant    = grant_reg;
  assign grant_id = grant_id_reg;
  assign load     = load_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Self-checking bench for rr_grant_scheduler: directed scenarios followed by
// random traffic, all compared every cycle against a behavioural model.
module tb_rr_grant_scheduler;

  localparam int W  = 4;
  localparam int TO = 8;

  logic         clock;
  logic         reset;
  logic [W-1:0] req;
  logic         ack;
  logic [W-1:0] grant;
  logic [1:0]   grant_id;
  logic         load;
  logic         busy;
  logic         timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0 = nobody granted, 1 = granted & loading, 2 = granted & acked.
  int m_mode = 0;
  int m_ptr  = 0;
  int m_id   = 0;
  int m_cnt  = 0;
  int m_to   = 0;

  rr_grant_scheduler #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .ack      (ack),
    .grant    (grant),
    .grant_id (grant_id),
    .load     (load),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_ptr = 0; m_id = 0; m_cnt = 0; m_to = 0;
  endtask

  function automatic int pick(input logic [W-1:0] r, input int p);
    for (int k = 0; k < W; k++) begin
      if (r[(p + k) % W]) return (p + k) % W;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [W-1:0] r, input logic a);
    int w;
    bit fire;
    m_to = 0;
    fire = 0;
    if (m_mode == 0) begin
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_mode = 1; m_id = w; m_cnt = 0;
      end
    end else begin
`ifdef RR_SCHED_TIMEOUT_EN
      if (m_cnt == TO - 1) fire = 1;
      m_cnt++;
`endif
      if (fire) begin
        m_mode = 0; m_to = 1; m_ptr = (m_id + 1) % W;
      end else if (m_mode == 1) begin
        if (a) begin
          m_mode = 2; m_ptr = (m_id + 1) % W;
        end else if (!r[m_id]) begin
          m_mode = 0;
        end
      end else if (!r[m_id]) begin
        m_mode = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] eg;
    eg = (m_mode != 0) ? (W'(1) << m_id) : '0;
    check("grant",    32'(grant),    32'(eg));
    check("grant_id", 32'(grant_id), 32'(m_id));
    check("load",     32'(load),     32'(m_mode == 1));
    check("busy",     32'(busy),     32'(m_mode != 0));
    check("timeout",  32'(timeout),  32'(m_to));
  endtask

  // Drive inputs, let one rising edge pass, advance the model, compare.
  task automatic cycle(input logic [W-1:0] r, input logic a);
    req = r;
    ack = a;
    @(posedge clock);
    model_step(r, a);
    #1;
    check_outputs();
    $display("cyc req=%b ack=%b -> grant=%b id=%0d load=%b busy=%b to=%b",
             r, a, grant, grant_id, load, busy, timeout);
  endtask

  task automatic reset_pulse();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("async_rst_grant", 32'(grant), 32'd0);
    check("async_rst_load",  32'(load),  32'd0);
    check("async_rst_busy",  32'(busy),  32'd0);
    repeat (2) begin
      req = 4'($urandom_range(0, 15));
      @(posedge clock);
      #1;
      check_outputs();
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    logic [W-1:0] exp_rot [5];
    exp_rot[0] = 4'b0001; exp_rot[1] = 4'b0010; exp_rot[2] = 4'b0100;
    exp_rot[3] = 4'b1000; exp_rot[4] = 4'b0001;

    // Reset held with all requesting: nothing granted.
    reset = 1'b0;
    req   = 4'b1111;
    ack   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    model_reset();
    check("rst_grant",    32'(grant),    32'd0);
    check("rst_load",     32'(load),     32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_timeout",  32'(timeout),  32'd0);
    @(negedge clock);
    reset = 1'b1;
    cycle(4'b1111, 1'b0);
    check("first_grant", 32'(grant), 32'b0001);
    check("first_load",  32'(load),  32'd1);
    cycle(4'b1111, 1'b1);
    cycle(4'b1110, 1'b0);

    // Rotation: ptr is now 1, so the order continues 0010, 0100, 1000, 0001.
    // Re-run from the first grant so the five-step rotation is visible.
    reset_pulse();
    for (int k = 0; k < 5; k++) begin
      cycle(4'b1111, 1'b0);
      check("rotation", 32'(grant), 32'(exp_rot[k]));
      cycle(4'b1111, 1'b1);
      check("rot_hold_load", 32'(load), 32'd0);
      cycle(4'b1111 & ~exp_rot[k], 1'b0);
      check("rot_release", 32'(grant), 32'd0);
    end

    // Fairness skip: ptr=1, req=1001 -> 1000, then ptr wraps to 0 -> 0001.
    cycle(4'b1001, 1'b0);
    check("skip_grant", 32'(grant), 32'b1000);
    cycle(4'b1001, 1'b1);
    cycle(4'b0001, 1'b0);
    cycle(4'b1001, 1'b0);
    check("wrap_grant", 32'(grant), 32'b0001);
    cycle(4'b1001, 1'b1);
    cycle(4'b1000, 1'b0);

    // Withdraw: ptr=1 grants 0100; dropping req[2] without ack leaves ptr at 1.
    cycle(4'b0100, 1'b0);
    check("wd_grant", 32'(grant), 32'b0100);
    cycle(4'b0000, 1'b0);
    check("wd_drop", 32'(grant), 32'd0);
    cycle(4'b1100, 1'b0);
    check("wd_regrant", 32'(grant), 32'b0100);

    // Ack and withdraw together: HOLD first, grant drops one cycle later.
    cycle(4'b1000, 1'b1);
    check("aw_hold_grant", 32'(grant), 32'b0100);
    check("aw_hold_busy",  32'(busy),  32'd1);
    cycle(4'b1000, 1'b0);
    check("aw_release", 32'(grant), 32'd0);
    cycle(4'b1111, 1'b0);
    check("aw_ptr_adv", 32'(grant), 32'b1000);
    cycle(4'b1111, 1'b1);
    cycle(4'b0111, 1'b0);

`ifdef RR_SCHED_TIMEOUT_EN
    // Watchdog: no ack, grant survives TO cycles, then revoked with a pulse.
    cycle(4'b0011, 1'b0);
    check("to_grant", 32'(grant), 32'b0001);
    for (int k = 0; k < TO - 1; k++) cycle(4'b0011, 1'b0);
    cycle(4'b0011, 1'b0);
    check("to_revoked", 32'(grant),   32'd0);
    check("to_pulse",   32'(timeout), 32'd1);
    cycle(4'b0011, 1'b0);
    check("to_next",    32'(grant),   32'b0010);
    check("to_clear",   32'(timeout), 32'd0);
`endif

    // Random traffic; the granted requester tends to hold its request.
    for (int n = 0; n < 1500; n++) begin
      logic [W-1:0] r;
      logic         a;
      r = 4'($urandom_range(0, 15));
      if (m_mode == 1 && $urandom_range(0, 7) != 0) r[m_id] = 1'b1;
      if (m_mode == 2 && $urandom_range(0, 1) != 0) r[m_id] = 1'b1;
      a = ($urandom_range(0, 2) == 0);
      cycle(r, a);
      if (n == 700) reset_pulse();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
